wb_arbiter_rr_2: RTL and testbench

//  Two-master Wishbone classic arbiter. Sits directly upstream of the 2-port

---
 rtl/wb_arbiter_rr_2_arb.sv | 33 +++
 rtl/wb_arbiter_rr_2.sv | 124 ++++++++++++
 tb/tb_wb_arbiter_rr_2.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_rr_2_arb.sv
// Two-port grant selector: keeps the current owner while it requests, otherwise
// picks between the requesters by round-robin or fixed priority.
module arb_rr_2 #(
   parameter bit ARB_TYPE_RR  = 1'b1,
   parameter bit LSB_PRIORITY = 1'b1
) (
   input  logic [1:0] req,
   input  logic [1:0] cur,
   input  logic       last_grant,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (cur[0] && req[0])
         gnt = 2'b01;
      else if (cur[1] && req[1])
         gnt = 2'b10;
      else begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
               // Round-robin favours the port that did not win last time.
               if (ARB_TYPE_RR) gnt = last_grant ? 2'b01 : 2'b10;
               else             gnt = LSB_PRIORITY ? 2'b01 : 2'b10;
            end
            default: gnt = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/wb_arbiter_rr_2.sv
// Two-master Wishbone classic arbiter: registered grant held for the whole
// cycle, responses routed back only to the granted master.
module wb_arbiter_rr_2 #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter bit ARB_TYPE_RR  = 1'b1,
   parameter bit LSB_PRIORITY = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
   input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
   output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
   input  logic                    wbm0_we_i,
   input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
   input  logic                    wbm0_stb_i,
   output logic                    wbm0_ack_o,
   output logic                    wbm0_err_o,
   output logic                    wbm0_rty_o,
   input  logic                    wbm0_cyc_i,
   input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
   input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
   output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
   input  logic                    wbm1_we_i,
   input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
   input  logic                    wbm1_stb_i,
   output logic                    wbm1_ack_o,
   output logic                    wbm1_err_o,
   output logic                    wbm1_rty_o,
   input  logic                    wbm1_cyc_i,
   output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
   input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
   output logic [DATA_WIDTH-1:0]   wbs_dat_o,
   output logic                    wbs_we_o,
   output logic [SELECT_WIDTH-1:0] wbs_sel_o,
   output logic                    wbs_stb_o,
   input  logic                    wbs_ack_i,
   input  logic                    wbs_err_i,
   input  logic                    wbs_rty_i,
   output logic                    wbs_cyc_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] GNT0 = 2'd1;
   localparam logic [1:0] GNT1 = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = IDLE,
      S_GNT0 = GNT0,
      S_GNT1 = GNT1
   } state_t;

   state_t     state, state_nxt;
   logic       last_grant;
   logic [1:0] gnt;
   logic       own0, own1;

   assign own0 = (state == S_GNT0);
   assign own1 = (state == S_GNT1);

   arb_rr_2 #(
      .ARB_TYPE_RR  (ARB_TYPE_RR),
      .LSB_PRIORITY (LSB_PRIORITY)
   ) u_arb (
      .req        ({wbm1_cyc_i, wbm0_cyc_i}),
      .cur        ({own1, own0}),
      .last_grant (last_grant),
      .gnt        (gnt)
   );

   always_comb begin
      state_nxt = S_IDLE;
      if (gnt[0])      state_nxt = S_GNT0;
      else if (gnt[1]) state_nxt = S_GNT1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
      end else begin
         state <= state_nxt;
         // Only a fresh grant moves the round-robin pointer.
         if (state_nxt != state && state_nxt != S_IDLE)
            last_grant <= (state_nxt == S_GNT1);
      end
   end

   always_comb begin
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      wbs_we_o  = 1'b0;
      wbs_sel_o = '0;
      wbs_stb_o = 1'b0;
      wbs_cyc_o = 1'b0;
      if (own0) begin
         wbs_adr_o = wbm0_adr_i;
         wbs_dat_o = wbm0_dat_i;
         wbs_we_o  = wbm0_we_i;
         wbs_sel_o = wbm0_sel_i;
         wbs_stb_o = wbm0_stb_i & wbm0_cyc_i;
         wbs_cyc_o = wbm0_cyc_i;
      end else if (own1) begin
         wbs_adr_o = wbm1_adr_i;
         wbs_dat_o = wbm1_dat_i;
         wbs_we_o  = wbm1_we_i;
         wbs_sel_o = wbm1_sel_i;
         wbs_stb_o = wbm1_stb_i & wbm1_cyc_i;
         wbs_cyc_o = wbm1_cyc_i;
      end
   end

   // A response arriving after the owner dropped CYC is swallowed.
   assign wbm0_ack_o = wbs_ack_i & own0 & wbm0_cyc_i;
   assign wbm0_err_o = wbs_err_i & own0 & wbm0_cyc_i;
   assign wbm0_rty_o = wbs_rty_i & own0 & wbm0_cyc_i;
   assign wbm1_ack_o = wbs_ack_i & own1 & wbm1_cyc_i;
   assign wbm1_err_o = wbs_err_i & own1 & wbm1_cyc_i;
   assign wbm1_rty_o = wbs_rty_i & own1 & wbm1_cyc_i;
   assign wbm0_dat_o = wbs_dat_i;
   assign wbm1_dat_o = wbs_dat_i;

endmodule

// File: tb/tb_wb_arbiter_rr_2.sv
// Directed bench: a round-robin and a fixed-priority arbiter driven by the
// same master/slave stimulus, each step checked against hand-derived values.
module tb_wb_arbiter_rr_2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
   logic [3:0]  m0_sel, m1_sel;
   logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
   logic        s_ack, s_err, s_rty;

   logic [31:0] r_m0_dat, r_m1_dat, r_adr, r_wdat;
   logic [3:0]  r_sel;
   logic        r_m0_ack, r_m0_err, r_m0_rty, r_m1_ack, r_m1_err, r_m1_rty;
   logic        r_we, r_stb, r_cyc;
   logic [31:0] f_m0_dat, f_m1_dat, f_adr, f_wdat;
   logic [3:0]  f_sel;
   logic        f_m0_ack, f_m0_err, f_m0_rty, f_m1_ack, f_m1_err, f_m1_rty;
   logic        f_we, f_stb, f_cyc;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   wb_arbiter_rr_2 #(.ARB_TYPE_RR(1'b1), .LSB_PRIORITY(1'b1)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .wbm0_adr_i(m0_adr), .wbm0_dat_i(m0_dat), .wbm0_dat_o(r_m0_dat), .wbm0_we_i(m0_we),
      .wbm0_sel_i(m0_sel), .wbm0_stb_i(m0_stb), .wbm0_ack_o(r_m0_ack), .wbm0_err_o(r_m0_err),
      .wbm0_rty_o(r_m0_rty), .wbm0_cyc_i(m0_cyc),
      .wbm1_adr_i(m1_adr), .wbm1_dat_i(m1_dat), .wbm1_dat_o(r_m1_dat), .wbm1_we_i(m1_we),
      .wbm1_sel_i(m1_sel), .wbm1_stb_i(m1_stb), .wbm1_ack_o(r_m1_ack), .wbm1_err_o(r_m1_err),
      .wbm1_rty_o(r_m1_rty), .wbm1_cyc_i(m1_cyc),
      .wbs_adr_o(r_adr), .wbs_dat_i(s_dat), .wbs_dat_o(r_wdat), .wbs_we_o(r_we),
      .wbs_sel_o(r_sel), .wbs_stb_o(r_stb), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
      .wbs_rty_i(s_rty), .wbs_cyc_o(r_cyc)
   );

   wb_arbiter_rr_2 #(.ARB_TYPE_RR(1'b0), .LSB_PRIORITY(1'b1)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .wbm0_adr_i(m0_adr), .wbm0_dat_i(m0_dat), .wbm0_dat_o(f_m0_dat), .wbm0_we_i(m0_we),
      .wbm0_sel_i(m0_sel), .wbm0_stb_i(m0_stb), .wbm0_ack_o(f_m0_ack), .wbm0_err_o(f_m0_err),
      .wbm0_rty_o(f_m0_rty), .wbm0_cyc_i(m0_cyc),
      .wbm1_adr_i(m1_adr), .wbm1_dat_i(m1_dat), .wbm1_dat_o(f_m1_dat), .wbm1_we_i(m1_we),
      .wbm1_sel_i(m1_sel), .wbm1_stb_i(m1_stb), .wbm1_ack_o(f_m1_ack), .wbm1_err_o(f_m1_err),
      .wbm1_rty_o(f_m1_rty), .wbm1_cyc_i(m1_cyc),
      .wbs_adr_o(f_adr), .wbs_dat_i(s_dat), .wbs_dat_o(f_wdat), .wbs_we_o(f_we),
      .wbs_sel_o(f_sel), .wbs_stb_o(f_stb), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
      .wbs_rty_i(s_rty), .wbs_cyc_o(f_cyc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("%s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0; m0_stb = 1'b0; m0_cyc = 1'b0;
      m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
      s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      #2;
      chk("reset_cyc", r_cyc, 0);
      chk("reset_stb", r_stb, 0);
      chk("reset_adr", r_adr, 0);
      chk("reset_m0_ack", r_m0_ack, 0);
      tick(); tick();
      rst_n = 1'b1;

      // single master on port 1
      m1_adr = 32'h1000; m1_dat = 32'hDEAD; m1_we = 1'b1; m1_sel = 4'hF;
      m1_cyc = 1'b1; m1_stb = 1'b1;
      #1 chk("single_latency", r_cyc, 0);
      tick();
      chk("single_cyc", r_cyc, 1);
      chk("single_adr", r_adr, 32'h1000);
      chk("single_stb", r_stb, 1);
      chk("single_wdat", r_wdat, 32'hDEAD);
      chk("single_sel", r_sel, 4'hF);
      s_ack = 1'b1; s_dat = 32'hCAFE;
      #1;
      chk("single_m1_ack", r_m1_ack, 1);
      chk("single_m0_ack", r_m0_ack, 0);
      chk("single_rdat_bcast", r_m0_dat, 32'hCAFE);
      s_ack = 1'b0; s_err = 1'b1;
      #1 chk("single_m1_err", r_m1_err, 1);
      s_err = 1'b0; s_rty = 1'b1;
      #1 chk("single_m1_rty", r_m1_rty, 1);
      chk("single_m0_rty", r_m0_rty, 0);
      s_rty = 1'b0;
      m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
      tick();
      chk("single_idle", r_cyc, 0);

      // simultaneous request, last winner was port 1 -> port 0
      m0_adr = 32'hA0; m1_adr = 32'hB1;
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      tick();
      chk("rr_first_adr", r_adr, 32'hA0);
      s_ack = 1'b1;
      #1 chk("rr_first_m0_ack", r_m0_ack, 1);
      chk("rr_first_m1_ack", r_m1_ack, 0);
      s_ack = 1'b0;
      m0_cyc = 1'b0; m0_stb = 1'b0;
      #1 chk("rr_drop_cyc_comb", r_cyc, 0);
      tick();
      chk("rr_handoff_adr", r_adr, 32'hB1);
      chk("rr_handoff_cyc", r_cyc, 1);
      m1_cyc = 1'b0; m1_stb = 1'b0;
      tick();
      chk("rr_idle", r_cyc, 0);
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      tick();
      chk("rr_again_adr", r_adr, 32'hA0);

      // reset mid-cycle with port 0 granted
      s_ack = 1'b1;
      #1 chk("rst_pre_ack", r_m0_ack, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_cyc", r_cyc, 0);
      chk("rst_async_ack", r_m0_ack, 0);
      chk("rst_async_adr", r_adr, 0);
      s_ack = 1'b0;
      m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_idle_rr", r_cyc, 0);
      chk("rst_idle_fp", f_cyc, 0);

      // hold: 4-beat burst on port 0 with port 1 waiting
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         m0_adr = 32'h100 + 32'(4 * i);
         s_ack = 1'b1;
         #1;
         chk("hold_adr", r_adr, 32'h100 + 32'(4 * i));
         chk("hold_m0_ack", r_m0_ack, 1);
         chk("hold_m1_ack", r_m1_ack, 0);
         tick();
      end
      s_ack = 1'b0;
      m0_cyc = 1'b0; m0_stb = 1'b0;
      tick();
      chk("hold_handoff_adr", r_adr, 32'hB1);
      m1_cyc = 1'b0; m1_stb = 1'b0;
      tick();

      // fixed priority: port 0 always wins, port 1 only while port 0 is idle
      m0_adr = 32'hA0;
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         s_ack = 1'b1;
         #1;
         chk("fp_c1_adr", f_adr, 32'hA0);
         chk("fp_c1_m1_ack", f_m1_ack, 0);
         tick();
      end
      s_ack = 1'b0;
      m0_cyc = 1'b0; m0_stb = 1'b0;
      tick();
      chk("fp_p1_adr", f_adr, 32'hB1);
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b0; m1_stb = 1'b0;
      tick();
      m1_cyc = 1'b1; m1_stb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_ack = 1'b1;
         #1;
         chk("fp_c2_adr", f_adr, 32'hA0);
         chk("fp_c2_m0_ack", f_m0_ack, 1);
         tick();
      end
      s_ack = 1'b0;
      m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
      tick();
      // last RR winner was port 0, so RR now picks port 1; fixed picks port 0
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      tick();
      chk("rr_vs_fp_rr", r_adr, 32'hB1);
      chk("rr_vs_fp_fp", f_adr, 32'hA0);
      m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
      tick();

      // abort: owner drops CYC with STB pending, late ACK is dropped
      m0_cyc = 1'b1; m0_stb = 1'b1;
      tick();
      chk("abort_granted", r_cyc, 1);
      m0_cyc = 1'b0;
      #1;
      chk("abort_stb", r_stb, 0);
      chk("abort_cyc", r_cyc, 0);
      tick();
      s_ack = 1'b1;
      #1;
      chk("abort_m0_ack", r_m0_ack, 0);
      chk("abort_m1_ack", r_m1_ack, 0);
      chk("abort_fp_m0_ack", f_m0_ack, 0);
      s_ack = 1'b0; m0_stb = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
